icache_fill_arbiter: RTL and testbench
======================================

# icache_fill_arbiter

Sits between the pipelined instruction cache and the single 256-bit memory read port. Arbitrates demand miss fills and next-line prefetches onto that port. Each accepted demand miss captures the cache's prefetch-target address and issues it as a prefetch once the port is free. Prefetched lines return on the cache's prefetch interface. A demand miss that matches the in-flight prefetch line is merged into it instead of being re-requested.

## Interface
Parameters:
- None; line size fixed at 256 bits, line address = addr[31:5].

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- dmd_addr  in  32  demand miss address (cache dfp_addr).
- dmd_read  in  1  demand request; held high until dmd_resp.
- dmd_rdata  out  256  demand fill line; valid only when dmd_resp=1, else 0.
- dmd_resp  out  1  one-cycle demand completion pulse.
- pf_req_addr  in  32  prefetch target (cache prefetch_outgoing_addr); sampled only on demand accept.
- pf_kill  in  1  flush (branch redirect): drops the pending prefetch and the in-flight prefetch result.
- pf_addr  out  32  line address of the returned prefetch, low 5 bits 0.
- pf_rdata  out  256  prefetched line.
- pf_resp  out  1  one-cycle prefetch delivery pulse.
- mem_addr  out  32  memory line address, low 5 bits always 0.
- mem_read  out  1  memory read; held stable until mem_resp.
- mem_rdata  in  256  memory return data.
- mem_resp  in  1  one-cycle memory completion.

## Operation
- States: IDLE, DEMAND, PREFETCH. mem_addr and mem_read derive from registered state only, never combinationally from dmd_read.
- IDLE, dmd_read=1 (demand accepted):
  - Latch dmd line into cur_line; go to DEMAND.
  - Capture pend_line <= pf_req_addr[31:5].
  - Set pend_valid only if all hold: the line differs from the demand line; the line differs from last_line while last_valid=1; pf_kill=0.
- IDLE, dmd_read=0, pend_valid=1, pf_kill=0:
  - cur_line <= pend_line; pend_valid <= 0; drop <= 0; go to PREFETCH.
- DEMAND: mem_read=1, mem_addr={cur_line,5'b0}.
  - On mem_resp: dmd_resp=1, dmd_rdata=mem_rdata; go to IDLE.
- PREFETCH: mem_read=1, mem_addr={cur_line,5'b0}.
  - merge <= 1 whenever dmd_read=1 and dmd_addr[31:5]==cur_line.
  - On mem_resp with drop=0: pf_resp=1, pf_addr={cur_line,5'b0}, pf_rdata=mem_rdata; last_line <= cur_line; last_valid <= 1.
  - On mem_resp with merge=1, or with a same-cycle matching dmd_read: also dmd_resp=1, dmd_rdata=mem_rdata. The merged response is delivered even if drop=1.
  - On mem_resp: go to IDLE; clear merge and drop.
  - A non-matching dmd_read waits; it is accepted in IDLE the next cycle.
- pf_kill, any state: pend_valid <= 0. In PREFETCH it also sets drop <= 1. A transaction already on mem is never aborted.
- last_valid clears on rst and on pf_kill.
- Demand always has priority over a pending prefetch in IDLE.

## Timing
- Reset: state=IDLE; pend_valid, last_valid, merge, drop = 0. All outputs 0: mem_read, mem_addr, dmd_resp, dmd_rdata, pf_resp, pf_addr, pf_rdata.
- Reset mid-transaction discards everything. The next mem_resp seen in IDLE is ignored and produces no response.
- Demand latency: dmd_read sampled in IDLE at edge N -> mem_read high from cycle N+1.
- dmd_resp and pf_resp are combinational with mem_resp, same cycle.
- After any mem_resp, the arbiter spends one cycle in IDLE; there are no back-to-back mem_read cycles.
- Prefetch issue: the earliest issue is the first IDLE cycle with dmd_read=0. In the cache's normal flow this is 1 cycle after dmd_resp, so mem_read rises 2 cycles after dmd_resp.
- Single pending slot: a later accepted demand overwrites pend_line.

## Test plan
- Demand only: dmd_read with dmd_addr=0x0000_1004, pf_req_addr=0x0000_1004 (same line) -> mem_addr=0x0000_1000 one cycle later; dmd_resp and data on mem_resp; no prefetch issued.
- Next-line: demand 0x0000_1000 with pf_req_addr=0x0000_1020 -> after dmd_resp, mem_addr=0x0000_1020 issued; pf_resp with pf_addr=0x0000_1020 and matching data. A second demand 0x0000_1000 does not re-prefetch 0x1020 (last_line suppression).
- Merge: during PREFETCH of 0x0000_2020, dmd_read with 0x0000_2024 -> a single mem transaction; dmd_resp and pf_resp in the same cycle with identical data; no second mem_read.
- Conflict: during PREFETCH of 0x0000_2020, dmd_read with 0x0000_3000 -> dmd waits; mem_addr=0x0000_3000 issued one idle cycle after the prefetch mem_resp.
- Kill: pf_kill while PREFETCH of 0x0000_4020 is outstanding -> mem_read stays high until mem_resp; pf_resp stays 0; pending cleared.
- Reset mid-DEMAND: rst for one cycle -> all outputs 0 next cycle; a stray mem_resp produces no dmd_resp or pf_resp.

Source files
------------

// File: rtl/icache_fill_arbiter.sv
// Arbitrates I-cache demand miss fills and next-line prefetches onto one 256-bit memory read port.
// A demand that hits the in-flight prefetch line is merged into that transaction.
module icache_fill_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dmd_addr,
  input  logic         dmd_read,
  output logic [255:0] dmd_rdata,
  output logic         dmd_resp,
  input  logic [31:0]  pf_req_addr,
  input  logic         pf_kill,
  output logic [31:0]  pf_addr,
  output logic [255:0] pf_rdata,
  output logic         pf_resp,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} state_t;

  state_t      state;
  logic [26:0] cur_line;
  logic [26:0] pend_line;
  logic [26:0] last_line;
  logic        pend_valid;
  logic        last_valid;
  logic        merge;
  logic        drop;

  logic [26:0] dmd_line;
  logic [26:0] pf_line;
  logic        dmd_match;
  logic        pf_new;

  assign dmd_line  = dmd_addr[31:5];
  assign pf_line   = pf_req_addr[31:5];
  assign dmd_match = dmd_read && (dmd_line == cur_line);
  // A prefetch is only worth queuing if it is neither the demand line nor the line just delivered.
  assign pf_new    = (pf_line != dmd_line) && !(last_valid && (pf_line == last_line)) && !pf_kill;

  always_comb begin
    mem_read  = (state != IDLE);
    mem_addr  = mem_read ? {cur_line, 5'b0} : 32'b0;
    dmd_resp  = mem_resp && ((state == DEMAND) || ((state == PREFETCH) && (merge || dmd_match)));
    pf_resp   = mem_resp && (state == PREFETCH) && !drop;
    dmd_rdata = dmd_resp ? mem_rdata : 256'b0;
    pf_rdata  = pf_resp ? mem_rdata : 256'b0;
    pf_addr   = pf_resp ? {cur_line, 5'b0} : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      last_valid <= 1'b0;
      merge      <= 1'b0;
      drop       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmd_read) begin
            cur_line   <= dmd_line;
            pend_line  <= pf_line;
            pend_valid <= pf_new;
            state      <= DEMAND;
          end else if (pend_valid && !pf_kill) begin
            cur_line   <= pend_line;
            pend_valid <= 1'b0;
            drop       <= 1'b0;
            state      <= PREFETCH;
          end else if (pf_kill) begin
            pend_valid <= 1'b0;
          end
        end
        DEMAND: begin
          if (pf_kill) pend_valid <= 1'b0;
          if (mem_resp) state <= IDLE;
        end
        PREFETCH: begin
          if (pf_kill) begin
            pend_valid <= 1'b0;
            drop       <= 1'b1;
          end
          if (dmd_match) merge <= 1'b1;
          // The memory transaction always runs to completion; a kill only suppresses delivery.
          if (mem_resp) begin
            state <= IDLE;
            merge <= 1'b0;
            drop  <= 1'b0;
            if (!drop) begin
              last_line  <= cur_line;
              last_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (pf_kill) last_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_fill_arbiter.sv
// Directed bench for icache_fill_arbiter: demand, next-line prefetch, merge, conflict, kill, reset.
module tb_icache_fill_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dmd_addr;
  logic         dmd_read;
  logic [255:0] dmd_rdata;
  logic         dmd_resp;
  logic [31:0]  pf_req_addr;
  logic         pf_kill;
  logic [31:0]  pf_addr;
  logic [255:0] pf_rdata;
  logic         pf_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  icache_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .dmd_addr(dmd_addr), .dmd_read(dmd_read), .dmd_rdata(dmd_rdata), .dmd_resp(dmd_resp),
    .pf_req_addr(pf_req_addr), .pf_kill(pf_kill),
    .pf_addr(pf_addr), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmd_read = 1'b0; dmd_addr = '0; pf_req_addr = '0; pf_kill = 1'b0;
    mem_resp = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL rst_mem_read got %b want 0", mem_read); end
    cmp_cnt++; if (mem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    cmp_cnt++; if ({dmd_resp, pf_resp} !== 2'b00) begin err_cnt++; $display("FAIL rst_resp got %b want 00", {dmd_resp, pf_resp}); end
    cmp_cnt++; if ({dmd_rdata, pf_rdata, pf_addr} !== '0) begin err_cnt++; $display("FAIL rst_data got nonzero want 0"); end
  endtask

  // Demand whose prefetch target is the same line: no prefetch follows.
  task automatic test_demand_only();
    tick();
    dmd_read = 1'b1; dmd_addr = 32'h0000_1004; pf_req_addr = 32'h0000_1004;
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL dmd_lat0 mem_read got %b want 0", mem_read); end
    tick();
    mem_resp = 1'b1; mem_rdata = {8{32'hA1A1_0001}};
    @(negedge clk);
    cmp_cnt++; if (mem_addr !== 32'h0000_1000) begin err_cnt++; $display("FAIL dmd_addr got %h want 00001000", mem_addr); end
    cmp_cnt++; if (dmd_resp !== 1'b1) begin err_cnt++; $display("FAIL dmd_resp got %b want 1", dmd_resp); end
    cmp_cnt++; if (dmd_rdata !== {8{32'hA1A1_0001}}) begin err_cnt++; $display("FAIL dmd_rdata got %h want a1a10001..", dmd_rdata); end
    cmp_cnt++; if (pf_resp !== 1'b0) begin err_cnt++; $display("FAIL dmd_pf_resp got %b want 0", pf_resp); end
    tick();
    dmd_read = 1'b0; mem_resp = 1'b0;
    tick(); tick();
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL dmd_no_pf mem_read got %b want 0", mem_read); end
  endtask

  // Runs demand of dline with prefetch target pline; leaves the bench one cycle into PREFETCH.
  task automatic demand_then_prefetch(input logic [31:0] dline, input logic [31:0] pline, input logic [255:0] d);
    tick();
    dmd_read = 1'b1; dmd_addr = dline; pf_req_addr = pline;
    tick();
    mem_resp = 1'b1; mem_rdata = d;
    @(negedge clk);
    cmp_cnt++; if (dmd_rdata !== d) begin err_cnt++; $display("FAIL pre_dmd_rdata got %h want %h", dmd_rdata, d); end
    tick();
    dmd_read = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL pre_idle_gap mem_read got %b want 0", mem_read); end
    tick();
    @(negedge clk);
    cmp_cnt++; if ({mem_read, mem_addr} !== {1'b1, pline}) begin err_cnt++; $display("FAIL pf_issue got %b/%h want 1/%h", mem_read, mem_addr, pline); end
  endtask

  task automatic test_next_line();
    demand_then_prefetch(32'h0000_1000, 32'h0000_1020, {8{32'hB2B2_0002}});
    tick();
    mem_resp = 1'b1; mem_rdata = {8{32'hC3C3_0003}};
    @(negedge clk);
    cmp_cnt++; if (pf_resp !== 1'b1) begin err_cnt++; $display("FAIL nl_pf_resp got %b want 1", pf_resp); end
    cmp_cnt++; if (pf_addr !== 32'h0000_1020) begin err_cnt++; $display("FAIL nl_pf_addr got %h want 00001020", pf_addr); end
    cmp_cnt++; if (pf_rdata !== {8{32'hC3C3_0003}}) begin err_cnt++; $display("FAIL nl_pf_rdata got %h want c3c30003..", pf_rdata); end
    cmp_cnt++; if (dmd_resp !== 1'b0) begin err_cnt++; $display("FAIL nl_dmd_resp got %b want 0", dmd_resp); end
    // Repeat the same demand: the just-delivered line must not be prefetched again.
    tick();
    mem_resp = 1'b0; dmd_read = 1'b1; dmd_addr = 32'h0000_1000; pf_req_addr = 32'h0000_1020;
    tick();
    mem_resp = 1'b1; mem_rdata = {8{32'hD4D4_0004}};
    @(negedge clk);
    cmp_cnt++; if (dmd_resp !== 1'b1) begin err_cnt++; $display("FAIL nl2_dmd_resp got %b want 1", dmd_resp); end
    tick();
    dmd_read = 1'b0; mem_resp = 1'b0;
    tick(); tick();
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL nl_suppress mem_read got %b want 0", mem_read); end
  endtask

  task automatic test_merge();
    demand_then_prefetch(32'h0000_2000, 32'h0000_2020, {8{32'h1111_2000}});
    dmd_read = 1'b1; dmd_addr = 32'h0000_2024; pf_req_addr = 32'h0000_2024;
    tick();
    mem_resp = 1'b1; mem_rdata = {8{32'h2222_2020}};
    @(negedge clk);
    cmp_cnt++; if ({dmd_resp, pf_resp} !== 2'b11) begin err_cnt++; $display("FAIL mg_resp got %b want 11", {dmd_resp, pf_resp}); end
    cmp_cnt++; if (dmd_rdata !== {8{32'h2222_2020}}) begin err_cnt++; $display("FAIL mg_dmd_rdata got %h want 22222020..", dmd_rdata); end
    cmp_cnt++; if (pf_rdata !== {8{32'h2222_2020}}) begin err_cnt++; $display("FAIL mg_pf_rdata got %h want 22222020..", pf_rdata); end
    cmp_cnt++; if (pf_addr !== 32'h0000_2020) begin err_cnt++; $display("FAIL mg_pf_addr got %h want 00002020", pf_addr); end
    tick();
    dmd_read = 1'b0; mem_resp = 1'b0;
    tick(); tick();
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL mg_no_second mem_read got %b want 0", mem_read); end
  endtask

  task automatic test_conflict();
    // A one-cycle kill in IDLE clears the delivered-line history so 0x2020 may be prefetched again.
    tick();
    pf_kill = 1'b1;
    tick();
    pf_kill = 1'b0;
    demand_then_prefetch(32'h0000_2000, 32'h0000_2020, {8{32'h3333_2000}});
    dmd_read = 1'b1; dmd_addr = 32'h0000_3000; pf_req_addr = 32'h0000_3000;
    @(negedge clk);
    cmp_cnt++; if (mem_addr !== 32'h0000_2020) begin err_cnt++; $display("FAIL cf_hold_addr got %h want 00002020", mem_addr); end
    tick();
    mem_resp = 1'b1; mem_rdata = {8{32'h4444_2020}};
    @(negedge clk);
    cmp_cnt++; if ({dmd_resp, pf_resp} !== 2'b01) begin err_cnt++; $display("FAIL cf_resp got %b want 01", {dmd_resp, pf_resp}); end
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL cf_gap mem_read got %b want 0", mem_read); end
    tick();
    mem_resp = 1'b1; mem_rdata = {8{32'h5555_3000}};
    @(negedge clk);
    cmp_cnt++; if ({mem_read, mem_addr} !== {1'b1, 32'h0000_3000}) begin err_cnt++; $display("FAIL cf_issue got %b/%h want 1/00003000", mem_read, mem_addr); end
    cmp_cnt++; if ({dmd_resp, dmd_rdata} !== {1'b1, {8{32'h5555_3000}}}) begin err_cnt++; $display("FAIL cf_dmd got %b/%h", dmd_resp, dmd_rdata); end
    tick();
    dmd_read = 1'b0; mem_resp = 1'b0;
  endtask

  task automatic test_kill();
    demand_then_prefetch(32'h0000_4000, 32'h0000_4020, {8{32'h6666_4000}});
    pf_kill = 1'b1;
    tick();
    pf_kill = 1'b0;
    @(negedge clk);
    cmp_cnt++; if ({mem_read, mem_addr} !== {1'b1, 32'h0000_4020}) begin err_cnt++; $display("FAIL kl_hold got %b/%h want 1/00004020", mem_read, mem_addr); end
    tick();
    mem_resp = 1'b1; mem_rdata = {8{32'h7777_4020}};
    @(negedge clk);
    cmp_cnt++; if ({dmd_resp, pf_resp} !== 2'b00) begin err_cnt++; $display("FAIL kl_resp got %b want 00", {dmd_resp, pf_resp}); end
    cmp_cnt++; if (pf_rdata !== '0) begin err_cnt++; $display("FAIL kl_pf_rdata got %h want 0", pf_rdata); end
    tick();
    mem_resp = 1'b0;
    // Kill during DEMAND clears the pending prefetch captured at accept.
    dmd_read = 1'b1; dmd_addr = 32'h0000_5000; pf_req_addr = 32'h0000_5020;
    tick();
    pf_kill = 1'b1;
    tick();
    pf_kill = 1'b0; mem_resp = 1'b1; mem_rdata = {8{32'h8888_5000}};
    @(negedge clk);
    cmp_cnt++; if (dmd_resp !== 1'b1) begin err_cnt++; $display("FAIL kl2_dmd_resp got %b want 1", dmd_resp); end
    tick();
    dmd_read = 1'b0; mem_resp = 1'b0;
    tick(); tick();
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL kl2_pend_cleared mem_read got %b want 0", mem_read); end
  endtask

  task automatic test_reset_mid_demand();
    tick();
    dmd_read = 1'b1; dmd_addr = 32'h0000_6000; pf_req_addr = 32'h0000_6020;
    tick();
    @(negedge clk);
    cmp_cnt++; if ({mem_read, mem_addr} !== {1'b1, 32'h0000_6000}) begin err_cnt++; $display("FAIL rm_busy got %b/%h want 1/00006000", mem_read, mem_addr); end
    tick();
    rst = 1'b1; dmd_read = 1'b0;
    tick();
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = {8{32'h9999_6000}};
    @(negedge clk);
    cmp_cnt++; if ({mem_read, mem_addr} !== 33'b0) begin err_cnt++; $display("FAIL rm_mem got %b/%h want 0/0", mem_read, mem_addr); end
    cmp_cnt++; if ({dmd_resp, pf_resp} !== 2'b00) begin err_cnt++; $display("FAIL rm_stray_resp got %b want 00", {dmd_resp, pf_resp}); end
    cmp_cnt++; if ({dmd_rdata, pf_rdata, pf_addr} !== '0) begin err_cnt++; $display("FAIL rm_data got nonzero want 0"); end
    tick();
    mem_resp = 1'b0;
    tick();
    @(negedge clk);
    cmp_cnt++; if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL rm_no_pf mem_read got %b want 0", mem_read); end
  endtask

  initial begin
    test_reset();
    test_demand_only();
    test_next_line();
    test_merge();
    test_conflict();
    test_kill();
    test_reset_mid_demand();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
